// File: rtl/msdap_alu_sched_if.sv
// msdap_alu_sched_if: frame/ALU/result signal bundle for msdap_alu_sched
// master: drives start, frame, xl_In, xr_In, alu_done, alu_y; observes all outputs
// slave : the scheduler; drives alu_en, alu_ch, alu_sleep, yl_Out, yr_Out,
//         out_Valid, busy, overrun, timeout_err
interface msdap_alu_sched_if;
  logic        start, frame, alu_done;
  logic [15:0] xl_In, xr_In;
  logic [39:0] alu_y;
  logic        alu_en, alu_ch, alu_sleep, out_Valid, busy, overrun, timeout_err;
  logic [39:0] yl_Out, yr_Out;
  modport master (
    output start, frame, xl_In, xr_In, alu_done, alu_y,
    input  alu_en, alu_ch, alu_sleep, yl_Out, yr_Out, out_Valid, busy, overrun, timeout_err
  );
  modport slave (
    input  start, frame, xl_In, xr_In, alu_done, alu_y,
    output alu_en, alu_ch, alu_sleep, yl_Out, yr_Out, out_Valid, busy, overrun, timeout_err
  );
endinterface

// File: rtl/msdap_alu_sched.sv
// msdap_alu_sched: per-frame left-then-right scheduler for the shared MSDAP convolution ALU
// Ports: sClk (clock), reset (async, active-low), bus (msdap_alu_sched_if.slave):
//   in : start (sync restart), frame, xl_In, xr_In, alu_done, alu_y
//   out: alu_en, alu_ch, alu_sleep, yl_Out, yr_Out, out_Valid, busy, overrun, timeout_err
// Optional: define MSDAP_SCHED_SLEEP_EN to build the zero-run counter and SLEEP state.
module msdap_alu_sched #(
  parameter int unsigned ZERO_LIMIT = 800,
  parameter int unsigned TIMEOUT    = 1023
) (
  input logic              sClk,
  input logic              reset,
  msdap_alu_sched_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE,
    RUN_L,
    GAP,
`ifdef MSDAP_SCHED_SLEEP_EN
    RUN_R,
    SLEEP
`else
    RUN_R
`endif
  } state_t;
  state_t      state_q;
  logic [9:0]  timer_q;
  logic [39:0] hl_q, yl_q, yr_q;
  logic        alu_en_q, alu_ch_q, out_valid_q, busy_q, overrun_q, timeout_err_q;
  logic        tmo, fin;
  // timer_q counts cycles already spent in the channel, so this fires on the TIMEOUT-th cycle
  assign tmo = timer_q == 10'(TIMEOUT - 1);
  assign fin = bus.alu_done || tmo;
  assign bus.alu_en      = alu_en_q;
  assign bus.alu_ch      = alu_ch_q;
  assign bus.yl_Out      = yl_q;
  assign bus.yr_Out      = yr_q;
  assign bus.out_Valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_err_q;
`ifdef MSDAP_SCHED_SLEEP_EN
  logic [9:0] zc_q, zc_d;
  logic       zero, pend_q, sleep_q;
  assign zero = bus.xl_In == '0 && bus.xr_In == '0;
  assign zc_d = !zero ? '0 : &zc_q ? zc_q : zc_q + 10'd1;
  assign bus.alu_sleep = sleep_q;
`else
  logic unused_samples;
  assign unused_samples = ^{bus.xl_In, bus.xr_In};
  assign bus.alu_sleep = 1'b0;
`endif
  always_ff @(posedge sClk or negedge reset)
    if (!reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      hl_q          <= '0;
      yl_q          <= '0;
      yr_q          <= '0;
      alu_en_q      <= 1'b0;
      alu_ch_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef MSDAP_SCHED_SLEEP_EN
      zc_q          <= '0;
      pend_q        <= 1'b0;
      sleep_q       <= 1'b0;
`endif
    end else if (bus.start) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      hl_q          <= '0;
      yl_q          <= '0;
      yr_q          <= '0;
      alu_en_q      <= 1'b0;
      alu_ch_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef MSDAP_SCHED_SLEEP_EN
      zc_q          <= '0;
      pend_q        <= 1'b0;
      sleep_q       <= 1'b0;
`endif
    end else begin
      out_valid_q <= 1'b0;
      if (bus.frame && busy_q) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (bus.frame) begin
          state_q  <= RUN_L;
          alu_en_q <= 1'b1;
          alu_ch_q <= 1'b0;
          busy_q   <= 1'b1;
          timer_q  <= '0;
`ifdef MSDAP_SCHED_SLEEP_EN
          zc_q     <= zc_d;
          if (zc_d >= 10'(ZERO_LIMIT)) pend_q <= 1'b1;
`endif
        end
        RUN_L: begin
          timer_q <= timer_q + 10'd1;
          if (fin) begin
            // alu_done beats a coincident timeout, so no error in that case
            hl_q     <= bus.alu_done ? bus.alu_y : '0;
            if (!bus.alu_done) timeout_err_q <= 1'b1;
            state_q  <= GAP;
            alu_en_q <= 1'b0;
            alu_ch_q <= 1'b1;
          end
        end
        // one low alu_en cycle clears the ALU accumulators before the right channel
        GAP: begin
          state_q  <= RUN_R;
          alu_en_q <= 1'b1;
          timer_q  <= '0;
        end
        RUN_R: begin
          timer_q <= timer_q + 10'd1;
          if (fin) begin
            yl_q        <= hl_q;
            yr_q        <= bus.alu_done ? bus.alu_y : '0;
            if (!bus.alu_done) timeout_err_q <= 1'b1;
            out_valid_q <= 1'b1;
            alu_en_q    <= 1'b0;
            alu_ch_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MSDAP_SCHED_SLEEP_EN
            state_q     <= pend_q ? SLEEP : IDLE;
            sleep_q     <= pend_q;
            pend_q      <= 1'b0;
`else
            state_q     <= IDLE;
`endif
          end
        end
`ifdef MSDAP_SCHED_SLEEP_EN
        SLEEP: if (bus.frame) begin
          if (zero) begin
            zc_q        <= zc_d;
            out_valid_q <= 1'b1;
            yl_q        <= '0;
            yr_q        <= '0;
          end else begin
            zc_q     <= '0;
            sleep_q  <= 1'b0;
            state_q  <= RUN_L;
            alu_en_q <= 1'b1;
            alu_ch_q <= 1'b0;
            busy_q   <= 1'b1;
            timer_q  <= '0;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_msdap_alu_sched.sv
// tb_msdap_alu_sched: directed self-checking bench for msdap_alu_sched
module tb_msdap_alu_sched;
  logic sClk = 1'b0;
  logic reset = 1'b0;
  always #5 sClk = ~sClk;
  msdap_alu_sched_if bus();
  msdap_alu_sched dut (.sClk(sClk), .reset(reset), .bus(bus));
  int vec = 0;
  int errs = 0;
  logic [39:0] yl_val, yr_val;
  logic ok_l = 1'b1;
  logic ok_r = 1'b1;
  int lat_alu = 5;

  task automatic tick;
    @(posedge sClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic frame(input logic [15:0] xl, input logic [15:0] xr);
    bus.frame = 1'b1;
    bus.xl_In = xl;
    bus.xr_In = xr;
    tick;
    bus.frame = 1'b0;
  endtask

  // lat: cycle index of out_Valid counting the frame cycle as 0
  task automatic run(output int lat, output int gap);
    lat = 1;
    gap = 0;
    while (!bus.out_Valid && lat < 3000) begin
      if (bus.busy && !bus.alu_en) gap++;
      tick;
      lat++;
    end
  endtask

  task automatic wait_run_r;
    int k = 0;
    while (!(bus.alu_ch && bus.alu_en) && k < 100) begin
      tick;
      k++;
    end
  endtask

  // ALU model: result-ready after lat_alu enabled cycles, per-channel value
  initial begin
    int cnt = 0;
    bus.alu_done = 1'b0;
    bus.alu_y = '0;
    forever begin
      tick;
      bus.alu_done = 1'b0;
      if (bus.alu_en && (bus.alu_ch ? ok_r : ok_l)) begin
        cnt++;
        if (cnt == lat_alu) begin
          bus.alu_done = 1'b1;
          bus.alu_y = bus.alu_ch ? yr_val : yl_val;
          cnt = 0;
        end
      end else cnt = 0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, gap, nv;
    logic sl;
    bus.start = 1'b0;
    bus.frame = 1'b0;
    bus.xl_In = '0;
    bus.xr_In = '0;
    yl_val = 40'h12_3456_7890;
    yr_val = 40'hFE_DCBA_9876;
    repeat (3) tick;
    chk("rst_alu_en", bus.alu_en, 0);
    chk("rst_alu_ch", bus.alu_ch, 0);
    chk("rst_sleep", bus.alu_sleep, 0);
    chk("rst_yl", bus.yl_Out, 0);
    chk("rst_yr", bus.yr_Out, 0);
    chk("rst_valid", bus.out_Valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_tmo", bus.timeout_err, 0);
    reset = 1'b1;
    tick;
    frame(16'h0100, 16'hFF00);
    chk("en_after_frame", bus.alu_en, 1);
    chk("busy_after_frame", bus.busy, 1);
    run(n, gap);
    chk("latency", n, 12);
    chk("gap_cycles", gap, 1);
    chk("yl_basic", bus.yl_Out, 40'h12_3456_7890);
    chk("yr_basic", bus.yr_Out, 40'hFE_DCBA_9876);
    tick;
    chk("valid_one_cycle", bus.out_Valid, 0);
    chk("no_overrun", bus.overrun, 0);
    chk("no_tmo", bus.timeout_err, 0);
    // frame arriving in RUN_R is dropped but flags overrun
    yl_val = 40'h00_0000_00AA;
    yr_val = 40'h00_0000_00BB;
    frame(16'h1234, 16'h5678);
    wait_run_r;
    frame(16'h1111, 16'h2222);
    chk("overrun_set", bus.overrun, 1);
    run(n, gap);
    chk("ovr_valid", bus.out_Valid, 1);
    chk("ovr_yl", bus.yl_Out, 40'h00_0000_00AA);
    chk("ovr_yr", bus.yr_Out, 40'h00_0000_00BB);
    nv = 0;
    repeat (20) begin
      tick;
      if (bus.out_Valid) nv++;
    end
    chk("ovr_dropped", nv, 0);
    chk("ovr_idle", bus.busy, 0);
    // left channel never completes
    ok_l = 1'b0;
    yr_val = 40'h55_AAAA_5555;
    frame(16'h0001, 16'h0002);
    run(n, gap);
    chk("tmo_latency", n, 1030);
    chk("tmo_flag", bus.timeout_err, 1);
    chk("tmo_yl", bus.yl_Out, 0);
    chk("tmo_yr", bus.yr_Out, 40'h55_AAAA_5555);
    ok_l = 1'b1;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("start_clr_tmo", bus.timeout_err, 0);
    chk("start_clr_ovr", bus.overrun, 0);
    chk("start_clr_yr", bus.yr_Out, 0);
    // start beats a coincident frame
    bus.start = 1'b1;
    frame(16'h0005, 16'h0006);
    bus.start = 1'b0;
    chk("start_wins_busy", bus.busy, 0);
    chk("start_wins_en", bus.alu_en, 0);
    // start in mid-RUN_R aborts without a result
    frame(16'h0007, 16'h0008);
    wait_run_r;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_en", bus.alu_en, 0);
    chk("abort_ch", bus.alu_ch, 0);
    chk("abort_valid", bus.out_Valid, 0);
    chk("abort_yl", bus.yl_Out, 0);
    chk("abort_yr", bus.yr_Out, 0);
    nv = 0;
    repeat (20) begin
      tick;
      if (bus.out_Valid) nv++;
    end
    chk("abort_no_valid", nv, 0);
    yl_val = 40'h01_0203_0405;
    yr_val = 40'h0A_0B0C_0D0E;
    frame(16'h0009, 16'h000A);
    run(n, gap);
    chk("resume_latency", n, 12);
    chk("resume_yl", bus.yl_Out, 40'h01_0203_0405);
    chk("resume_yr", bus.yr_Out, 40'h0A_0B0C_0D0E);
`ifdef MSDAP_SCHED_SLEEP_EN
    sl = 1'b0;
    for (int i = 1; i <= 800; i++) begin
      frame(16'h0000, 16'h0000);
      if (bus.alu_sleep) sl = 1'b1;
      run(n, gap);
      if (i == 799) chk("sleep_before_limit", bus.alu_sleep, 0);
    end
    chk("sleep_early", sl, 0);
    chk("sleep_after_800", bus.alu_sleep, 1);
    frame(16'h0000, 16'h0000);
    chk("sleep_valid", bus.out_Valid, 1);
    chk("sleep_yl", bus.yl_Out, 0);
    chk("sleep_yr", bus.yr_Out, 0);
    chk("sleep_en", bus.alu_en, 0);
    tick;
    chk("sleep_valid_pulse", bus.out_Valid, 0);
    frame(16'h0001, 16'h0000);
    chk("wake_sleep", bus.alu_sleep, 0);
    chk("wake_en", bus.alu_en, 1);
    run(n, gap);
    chk("wake_latency", n, 12);
    chk("wake_yl", bus.yl_Out, 40'h01_0203_0405);
`else
    nv = 0;
    sl = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      frame(16'h0000, 16'h0000);
      run(n, gap);
      if (bus.out_Valid) nv++;
      if (bus.alu_sleep) sl = 1'b1;
    end
    chk("zero_valids", nv, 1000);
    chk("zero_no_sleep", sl, 0);
    chk("zero_sleep_final", bus.alu_sleep, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/msdap_alu_sched.md
# msdap_alu_sched

Frame-level scheduler that time-shares the single MSDAP convolution ALU between the left and right audio channels. For each input frame it runs the ALU on the left channel and then on the right, and captures each 40-bit result. It presents both results as one stereo output pulse. It also detects runs of zero input samples and parks the ALU in sleep until a non-zero sample arrives.

## Interface
- ZERO_LIMIT, 800: consecutive all-zero frames (both channels zero) before sleep.
- TIMEOUT, 1023: max sClk cycles a channel may wait for alu_done before abort.
- sClk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  synchronous restart; same effect as reset, one cycle.
- frame  in  1  one-cycle pulse: xl_In/xr_In hold a new sample pair.
- xl_In  in  16  left sample, sampled on frame.
- xr_In  in  16  right sample, sampled on frame.
- alu_done  in  1  ALU result-ready pulse (ALU prev_OutReady).
- alu_y  in  40  ALU result, valid with alu_done.
- alu_en  out  1  ALU enable; low for one or more cycles clears ALU accumulators.
- alu_ch  out  1  channel select to data/coeff memories: 0 = left, 1 = right.
- alu_sleep  out  1  ALU sleep request.
- yl_Out  out  40  last captured left result.
- yr_Out  out  40  last captured right result.
- out_Valid  out  1  one-cycle pulse: yl_Out/yr_Out updated together.
- busy  out  1  high in RUN_L, GAP, RUN_R.
- overrun  out  1  sticky: frame seen while busy; cleared only by reset/start.
- timeout_err  out  1  sticky: a channel exceeded TIMEOUT; cleared only by reset/start.

## Operation
- States: IDLE, RUN_L, GAP, RUN_R, SLEEP.
- IDLE: frame -> RUN_L. Latch samples and update the zero counter.
- RUN_L: alu_en=1, alu_ch=0, timer counts up.
  - alu_done -> capture alu_y into an internal left holding register -> GAP.
  - Timer reaches TIMEOUT -> left holding register := 0, timeout_err := 1 -> GAP.
- GAP: alu_en=0, alu_ch=1 for exactly one cycle -> RUN_R.
- RUN_R: alu_en=1, alu_ch=1.
  - alu_done or timeout (handled as in RUN_L, right register) -> commit both holding registers to yl_Out/yr_Out, pulse out_Valid -> IDLE.
- Zero counter: 10-bit saturating counter.
  - Frame with xl_In==0 and xr_In==0: increment.
  - Any non-zero sample: clear.
  - Reaching ZERO_LIMIT on a frame sets the sleep-pending flag. That frame still completes through RUN_R.
  - On return to IDLE with the flag set: -> SLEEP.
- SLEEP: alu_sleep=1, alu_en=0.
  - Zero frames: counted, no ALU run. out_Valid pulses with yl_Out=yr_Out=0 on the cycle after the frame.
  - Non-zero frame: clear counter, alu_sleep=0, -> RUN_L with that frame.
- Frame while busy: ignored (samples not latched), overrun := 1.
- alu_done in IDLE, GAP or SLEEP: ignored.
- Reset/start mid-run: immediate return to IDLE. All outputs go to their reset values and counters clear. No out_Valid is emitted.
- Reset values: alu_en=0, alu_ch=0, alu_sleep=0, yl_Out=yr_Out=0, out_Valid=0, busy=0, overrun=0, timeout_err=0. State IDLE, counters 0.

## Timing
- alu_en rises on the cycle after frame. All outputs are registered.
- Result latency = (left ALU cycles) + 1 GAP cycle + (right ALU cycles) + 1 cycle.
- out_Valid is asserted in the cycle after the right alu_done is sampled.
- The timer resets on entry to RUN_L and RUN_R.
- alu_done and the TIMEOUT expiry in the same cycle: alu_done wins and no error is flagged.
- frame and start in the same cycle: start wins and the frame is dropped.

## Configuration
- MSDAP_SCHED_SLEEP_EN defined: zero counter, sleep-pending flag and SLEEP state are built. alu_sleep behaves as described above.
- MSDAP_SCHED_SLEEP_EN undefined: no zero counter and no SLEEP state. alu_sleep is tied to 0, and every frame runs both channels.

## Test plan
- Reset, then frame with xl=0x0100, xr=0xFF00. ALU model returns 0x12_3456_7890 for left and 0xFE_DCBA_9876 for right, 5 cycles each. Required: one out_Valid pulse, 12 cycles after frame, with yl_Out/yr_Out equal to those values; alu_en low for exactly one cycle between channels.
- Second frame pulsed during RUN_R -> overrun=1. That frame is not processed; the current results are still delivered.
- ALU never asserts alu_done -> after 1023 cycles in RUN_L, timeout_err=1. The right channel then runs; yl_Out=0 and yr_Out holds the right result.
- 800 all-zero frames, with sleep enabled -> alu_sleep=1 after the 800th frame's result. The 801st zero frame gives out_Valid with zeros and alu_en stays 0. A frame with xl=0x0001 drops alu_sleep and starts RUN_L.
- start asserted in mid-RUN_R -> next cycle is IDLE with all outputs 0 and no out_Valid. Normal operation resumes on the next frame.
- Sleep macro undefined: 1000 zero frames -> alu_sleep stays 0 and 1000 out_Valid pulses are produced.
